tdc_measure_ctrl: RTL and testbench
===================================

Name: tdc_measure_ctrl

Overview:
- Sequences one TDC time-interval measurement: arm, wait for start edge, count coarse clock cycles, wait for stop edge, then present the result.
- Sits between the start/stop flip-flop capture columns with their thermometer decoders (fine bins) and the readout logic.
- Combines the coarse cycle count with the latched fine start/stop bins. Delivers the result over a valid/ready handshake.
- Guards each measurement with a timeout and an abort.

Parameters:
BITS_DECO, 8, width of fine bin numbers from the start/stop decoders
BITS_COARSE, 16, width of coarse cycle counter and result
TIMEOUT_CYCLES, 1000, coarse count at which a measurement without stop is closed; must satisfy 1 <= TIMEOUT_CYCLES < 2^BITS_COARSE

Ports:
wClk  in  1  system clock; all state changes on rising edge
wRstN  in  1  asynchronous active-low reset
wArm  in  1  request a measurement; sampled in IDLE and DONE (on handshake)
wAbort  in  1  cancel a measurement in ARMED or RUN; return to IDLE, no result
wStartHit  in  1  start column shows an edge this cycle (decoded bin is valid)
wStopHit  in  1  stop column shows an edge this cycle
wStartBin  in  BITS_DECO  decoded start bin, valid when wStartHit=1
wStopBin  in  BITS_DECO  decoded stop bin, valid when wStopHit=1
wCaptureEn  out  1  enables start/stop column sampling
wBusy  out  1  high in ARMED or RUN
wResultValid  out  1  result available
wResultReady  in  1  consumer accepts result
wResultCoarse  out  BITS_COARSE  coarse cycles from start-hit cycle to stop-hit cycle
wResultStartBin  out  BITS_DECO  latched start bin
wResultStopBin  out  BITS_DECO  latched stop bin (0 on timeout)
wResultTimeout  out  1  measurement closed by timeout

Behaviour:
- Reset (wRstN=0, async):
  - State goes to IDLE.
  - All outputs go to 0; coarse counter goes to 0.
  - A reset mid-operation discards any measurement or pending result.
- State IDLE:
  - wArm=1 moves to ARMED.
  - Hit inputs are ignored.
- State ARMED (wCaptureEn=1, wBusy=1):
  - wAbort=1 returns to IDLE. Abort has priority over hits.
  - wStartHit=1 latches wStartBin and clears the counter to 0.
  - If wStopHit=1 in the same cycle: latch wStopBin, set coarse=0, go to DONE.
  - Otherwise go to RUN.
  - wStopHit without wStartHit is ignored.
- State RUN (wCaptureEn=1, wBusy=1):
  - The counter increments every cycle. The first RUN cycle sees counter=0.
  - wAbort=1 returns to IDLE.
  - wStopHit=1 latches wStopBin, sets coarse=counter+1, timeout=0, and goes to DONE.
  - Otherwise, if counter+1 == TIMEOUT_CYCLES: coarse=TIMEOUT_CYCLES, stop bin=0, timeout=1, go to DONE.
  - A stop hit in the timeout cycle wins and is reported as a valid measurement.
  - wStartHit is ignored in RUN.
- State DONE (wCaptureEn=0, wBusy=0, wResultValid=1):
  - Result outputs stay stable while valid and not accepted.
  - Handshake occurs when wResultValid & wResultReady:
    - with wArm=1 in the same cycle, go to ARMED (back-to-back measurement);
    - otherwise go to IDLE.
  - wArm without handshake is ignored.
  - wAbort is ignored in DONE.
- Result registers:
  - Updated only on the transition into DONE.
  - Hold their value in IDLE; only wResultValid drops.
- Timing:
  - Outputs are registered.
  - wResultValid rises the cycle after the stop-hit cycle.
  - wCaptureEn rises the cycle after wArm is accepted.
- Arithmetic: the counter is BITS_COARSE wide and never wraps, because timeout bounds it.

Test Plan:
- Basic measurement: reset, arm. Start hit with bin 17 two cycles after arming; stop hit with bin 203 five cycles after start. Required: valid rises next cycle; coarse=5, start bin=17, stop bin=203, timeout=0.
- Start and stop in the same cycle (bins 4 and 90). Required: coarse=0 and DONE reached directly from ARMED.
- Timeout: TIMEOUT_CYCLES=10, start hit, no stop. Required: valid 11 cycles after start, coarse=10, stop bin=0, timeout=1. Repeat with stop hit exactly at counter+1=10: required coarse=10, timeout=0.
- Backpressure: hold wResultReady=0 for 20 cycles and toggle the hit inputs. Required: result stable and valid high throughout. Then ready=1 with wArm=1: required ARMED next cycle and wCaptureEn=1.
- Abort in ARMED and in RUN, including abort coinciding with a stop hit. Required: IDLE next cycle, no wResultValid, previous result registers unchanged.
- Assert wRstN=0 asynchronously mid-RUN and mid-DONE. Required: all outputs 0 immediately, IDLE after release; wArm before the start hit is ignored.

Source files
------------

// File: rtl/tdc_measure_ctrl_if.sv
// Result delivery bundle for tdc_measure_ctrl.
// The controller drives the result fields and wResultValid (master side).
// The readout logic returns wResultReady (slave side).
//   wResultValid     master->slave  result available
//   wResultReady     slave->master  consumer accepts result
//   wResultCoarse    master->slave  coarse cycles between start and stop hits
//   wResultStartBin  master->slave  latched fine start bin
//   wResultStopBin   master->slave  latched fine stop bin (0 on timeout)
//   wResultTimeout   master->slave  measurement closed by timeout
interface tdc_measure_ctrl_if #(
  parameter int unsigned BITS_DECO   = 8,
  parameter int unsigned BITS_COARSE = 16
);
  logic                   wResultValid;
  logic                   wResultReady;
  logic [BITS_COARSE-1:0] wResultCoarse;
  logic [BITS_DECO-1:0]   wResultStartBin;
  logic [BITS_DECO-1:0]   wResultStopBin;
  logic                   wResultTimeout;

  modport master (
    output wResultValid, wResultCoarse, wResultStartBin, wResultStopBin, wResultTimeout,
    input  wResultReady
  );

  modport slave (
    input  wResultValid, wResultCoarse, wResultStartBin, wResultStopBin, wResultTimeout,
    output wResultReady
  );
endinterface

// File: rtl/tdc_measure_ctrl.sv
// TDC time-interval measurement sequencer.
// The sequence is: arm, wait for a start hit, count coarse cycles, wait for a stop hit
// (or time out), then hold the result until the readout accepts it.
// Ports:
//   wClk, wRstN            clock, asynchronous active-low reset
//   wArm, wAbort           measurement request / cancel
//   wStartHit, wStartBin   start column edge and its decoded fine bin
//   wStopHit, wStopBin     stop column edge and its decoded fine bin
//   wCaptureEn             enables start/stop column sampling (ARMED/RUN)
//   wBusy                  measurement in progress (ARMED/RUN)
//   res                    result bundle (valid/ready handshake), master side
module tdc_measure_ctrl #(
  parameter int unsigned BITS_DECO      = 8,
  parameter int unsigned BITS_COARSE    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                 wClk,
  input  logic                 wRstN,
  input  logic                 wArm,
  input  logic                 wAbort,
  input  logic                 wStartHit,
  input  logic                 wStopHit,
  input  logic [BITS_DECO-1:0] wStartBin,
  input  logic [BITS_DECO-1:0] wStopBin,
  output logic                 wCaptureEn,
  output logic                 wBusy,
  tdc_measure_ctrl_if.master   res
);

  localparam logic [BITS_COARSE-1:0] TIMEOUT_VAL = BITS_COARSE'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [BITS_COARSE-1:0] cnt_q, cnt_d;
  logic [BITS_COARSE-1:0] cnt_inc;
  logic [BITS_DECO-1:0]   start_bin_q, start_bin_d;
  logic [BITS_COARSE-1:0] coarse_q, coarse_d;
  logic [BITS_DECO-1:0]   rstart_q, rstart_d;
  logic [BITS_DECO-1:0]   rstop_q, rstop_d;
  logic                   timeout_q, timeout_d;
  logic                   capture_q, capture_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;

  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge wClk or negedge wRstN) begin
    if (!wRstN) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      start_bin_q <= '0;
      coarse_q    <= '0;
      rstart_q    <= '0;
      rstop_q     <= '0;
      timeout_q   <= 1'b0;
      capture_q   <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      start_bin_q <= start_bin_d;
      coarse_q    <= coarse_d;
      rstart_q    <= rstart_d;
      rstop_q     <= rstop_d;
      timeout_q   <= timeout_d;
      capture_q   <= capture_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (wArm) state_d = S_ARMED;
      S_ARMED: begin
        // Abort wins over any hit in the same cycle.
        if (wAbort)         state_d = S_IDLE;
        else if (wStartHit) state_d = wStopHit ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (wAbort)                                  state_d = S_IDLE;
        else if (wStopHit || cnt_inc == TIMEOUT_VAL) state_d = S_DONE;
      end
      S_DONE:  if (res.wResultReady) state_d = wArm ? S_ARMED : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next state.
  // Result fields load only on entry into DONE and hold otherwise.
  always_comb begin
    cnt_d       = cnt_q;
    start_bin_d = start_bin_q;
    coarse_d    = coarse_q;
    rstart_d    = rstart_q;
    rstop_d     = rstop_q;
    timeout_d   = timeout_q;
    capture_d   = (state_d == S_ARMED) || (state_d == S_RUN);
    busy_d      = (state_d == S_ARMED) || (state_d == S_RUN);
    valid_d     = (state_d == S_DONE);

    if (state_q == S_ARMED && wStartHit && !wAbort) begin
      cnt_d       = '0;
      start_bin_d = wStartBin;
    end else if (state_q == S_RUN) begin
      cnt_d = cnt_inc;
    end

    if (state_d == S_DONE && state_q != S_DONE) begin
      if (state_q == S_ARMED) begin
        coarse_d  = '0;
        rstart_d  = wStartBin;
        rstop_d   = wStopBin;
        timeout_d = 1'b0;
      end else begin
        rstart_d = start_bin_q;
        // A stop hit in the timeout cycle still counts as a real measurement.
        if (wStopHit) begin
          coarse_d  = cnt_inc;
          rstop_d   = wStopBin;
          timeout_d = 1'b0;
        end else begin
          coarse_d  = TIMEOUT_VAL;
          rstop_d   = '0;
          timeout_d = 1'b1;
        end
      end
    end
  end

  assign wCaptureEn          = capture_q;
  assign wBusy               = busy_q;
  assign res.wResultValid    = valid_q;
  assign res.wResultCoarse   = coarse_q;
  assign res.wResultStartBin = rstart_q;
  assign res.wResultStopBin  = rstop_q;
  assign res.wResultTimeout  = timeout_q;

endmodule

// File: tb/tb_tdc_measure_ctrl.sv
// Self-checking bench for tdc_measure_ctrl (TIMEOUT_CYCLES=10).
// A table of measurements is applied in a loop; expected results are queued when a
// measurement is launched and compared when wResultValid rises. Hand-written sequences
// cover backpressure, abort, and asynchronous reset.
module tb_tdc_measure_ctrl;
  localparam int unsigned BD = 8;
  localparam int unsigned BC = 16;
  localparam int unsigned TO = 10;

  logic          wClk = 1'b0;
  logic          wRstN = 1'b0;
  logic          wArm = 1'b0;
  logic          wAbort = 1'b0;
  logic          wStartHit = 1'b0;
  logic          wStopHit = 1'b0;
  logic [BD-1:0] wStartBin = '0;
  logic [BD-1:0] wStopBin = '0;
  logic          wCaptureEn;
  logic          wBusy;

  tdc_measure_ctrl_if #(.BITS_DECO(BD), .BITS_COARSE(BC)) res_if ();

  tdc_measure_ctrl #(
    .BITS_DECO(BD),
    .BITS_COARSE(BC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .wClk(wClk),
    .wRstN(wRstN),
    .wArm(wArm),
    .wAbort(wAbort),
    .wStartHit(wStartHit),
    .wStopHit(wStopHit),
    .wStartBin(wStartBin),
    .wStopBin(wStopBin),
    .wCaptureEn(wCaptureEn),
    .wBusy(wBusy),
    .res(res_if.master)
  );

  always #5 wClk = ~wClk;

  typedef struct {
    int unsigned   pre;     // ARMED cycles before the start hit
    logic [BD-1:0] sbin;
    logic [BD-1:0] pbin;
    int unsigned   gap;     // cycles from start hit to stop hit (>TO: no stop)
    logic [BC-1:0] coarse;
    logic [BD-1:0] stopbin;
    logic          to;
    int unsigned   lat;     // cycles from start-hit edge to valid
  } vec_t;

  typedef struct {
    logic [BC-1:0] coarse;
    logic [BD-1:0] sbin;
    logic [BD-1:0] pbin;
    logic          to;
  } res_t;

  res_t        sb[$];
  int unsigned total = 0;
  int unsigned bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wClk);
    #1;
  endtask

  task automatic chk_result(input string tag, input res_t e);
    chk({tag, "_coarse"}, 32'(res_if.wResultCoarse), 32'(e.coarse));
    chk({tag, "_sbin"}, 32'(res_if.wResultStartBin), 32'(e.sbin));
    chk({tag, "_pbin"}, 32'(res_if.wResultStopBin), 32'(e.pbin));
    chk({tag, "_to"}, 32'(res_if.wResultTimeout), 32'(e.to));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cap"}, 32'(wCaptureEn), 0);
    chk({tag, "_busy"}, 32'(wBusy), 0);
    chk({tag, "_valid"}, 32'(res_if.wResultValid), 0);
    chk({tag, "_coarse"}, 32'(res_if.wResultCoarse), 0);
    chk({tag, "_sbin"}, 32'(res_if.wResultStartBin), 0);
    chk({tag, "_pbin"}, 32'(res_if.wResultStopBin), 0);
    chk({tag, "_to"}, 32'(res_if.wResultTimeout), 0);
  endtask

  task automatic run_meas(input vec_t v, input bit accept);
    res_t        e;
    int unsigned c;
    bit          got;
    e.coarse = v.coarse;
    e.sbin   = v.sbin;
    e.pbin   = v.stopbin;
    e.to     = v.to;
    sb.push_back(e);

    wArm = 1'b1;
    step();
    wArm = 1'b0;
    chk("cap_after_arm", 32'(wCaptureEn), 1);
    chk("busy_after_arm", 32'(wBusy), 1);
    repeat (v.pre) step();

    wStartHit = 1'b1;
    wStartBin = v.sbin;
    if (v.gap == 0) begin
      wStopHit = 1'b1;
      wStopBin = v.pbin;
    end
    step();
    wStartHit = 1'b0;
    wStopHit  = 1'b0;
    wStartBin = 8'($urandom);
    wStopBin  = 8'($urandom);

    c   = 0;
    got = res_if.wResultValid;
    while (!got && c < 40) begin
      c++;
      if (c == v.gap) begin
        wStopHit = 1'b1;
        wStopBin = v.pbin;
      end
      step();
      wStopHit = 1'b0;
      wStopBin = 8'($urandom);
      got = res_if.wResultValid;
    end

    if (!got) begin
      total++;
      bad++;
      $display("FAIL valid_wait: valid=0 after 40 cycles, want 1");
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      chk("latency", c, v.lat);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard: queue empty, want 1 entry");
      end else begin
        e = sb.pop_front();
        chk_result("meas", e);
      end
      chk("busy_done", 32'(wBusy), 0);
      chk("cap_done", 32'(wCaptureEn), 0);
    end

    if (accept) begin
      res_if.wResultReady = 1'b1;
      step();
      res_if.wResultReady = 1'b0;
      chk("valid_drop", 32'(res_if.wResultValid), 0);
      chk("busy_idle", 32'(wBusy), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    res_t last;

    tbl[0] = '{2, 8'd17,  8'd203, 5,  16'd5,  8'd203, 1'b0, 5};   // basic
    tbl[1] = '{0, 8'd4,   8'd90,  0,  16'd0,  8'd90,  1'b0, 0};   // same-cycle start/stop
    tbl[2] = '{1, 8'd33,  8'd12,  99, 16'd10, 8'd0,   1'b1, 10};  // timeout, no stop
    tbl[3] = '{0, 8'd50,  8'd60,  10, 16'd10, 8'd60,  1'b0, 10};  // stop in timeout cycle
    tbl[4] = '{3, 8'd255, 8'd1,   1,  16'd1,  8'd1,   1'b0, 1};
    tbl[5] = '{0, 8'd128, 8'd7,   9,  16'd9,  8'd7,   1'b0, 9};
    tbl[6] = '{0, 8'd9,   8'd77,  11, 16'd10, 8'd0,   1'b1, 10};  // stop too late

    res_if.wResultReady = 1'b0;

    // Reset state
    #12;
    chk_all_zero("reset");
    @(posedge wClk);
    #1 wRstN = 1'b1;

    // Hits in IDLE are ignored
    wStartHit = 1'b1;
    wStopHit  = 1'b1;
    step();
    wStartHit = 1'b0;
    wStopHit  = 1'b0;
    chk("idle_hits_busy", 32'(wBusy), 0);
    chk("idle_hits_valid", 32'(res_if.wResultValid), 0);

    for (int i = 0; i < 7; i++) run_meas(tbl[i], 1'b1);

    // Backpressure: result stays put, hits/arm/abort ignored while not accepted
    run_meas(tbl[0], 1'b0);
    last = '{16'd5, 8'd17, 8'd203, 1'b0};
    for (int i = 0; i < 20; i++) begin
      wStartHit = 1'($urandom);
      wStopHit  = 1'($urandom);
      wStartBin = 8'($urandom);
      wStopBin  = 8'($urandom);
      wArm      = 1'($urandom);
      wAbort    = 1'($urandom);
      step();
      chk("bp_valid", 32'(res_if.wResultValid), 1);
      chk_result("bp", last);
    end
    wStartHit = 1'b0;
    wStopHit  = 1'b0;
    wAbort    = 1'b0;
    wArm      = 1'b1;
    res_if.wResultReady = 1'b1;
    step();
    wArm = 1'b0;
    res_if.wResultReady = 1'b0;
    chk("b2b_cap", 32'(wCaptureEn), 1);
    chk("b2b_busy", 32'(wBusy), 1);
    chk("b2b_valid", 32'(res_if.wResultValid), 0);

    // Abort in ARMED (from the back-to-back arm above)
    wAbort = 1'b1;
    step();
    wAbort = 1'b0;
    chk("abort_armed_busy", 32'(wBusy), 0);
    chk("abort_armed_cap", 32'(wCaptureEn), 0);
    chk("abort_armed_valid", 32'(res_if.wResultValid), 0);
    chk_result("abort_armed_hold", last);

    // Abort in ARMED together with start and stop hits
    wArm = 1'b1;
    step();
    wArm      = 1'b0;
    wAbort    = 1'b1;
    wStartHit = 1'b1;
    wStopHit  = 1'b1;
    wStartBin = 8'd1;
    wStopBin  = 8'd2;
    step();
    wAbort    = 1'b0;
    wStartHit = 1'b0;
    wStopHit  = 1'b0;
    chk("abort_hits_busy", 32'(wBusy), 0);
    chk("abort_hits_valid", 32'(res_if.wResultValid), 0);
    chk_result("abort_hits_hold", last);

    // Abort in RUN coinciding with a stop hit
    wArm = 1'b1;
    step();
    wArm      = 1'b0;
    wStartHit = 1'b1;
    wStartBin = 8'd99;
    step();
    wStartHit = 1'b0;
    step();
    step();
    wAbort   = 1'b1;
    wStopHit = 1'b1;
    wStopBin = 8'd55;
    step();
    wAbort   = 1'b0;
    wStopHit = 1'b0;
    chk("abort_run_busy", 32'(wBusy), 0);
    chk("abort_run_valid", 32'(res_if.wResultValid), 0);
    chk_result("abort_run_hold", last);
    repeat (12) step();
    chk("abort_run_later_valid", 32'(res_if.wResultValid), 0);

    // Asynchronous reset mid-RUN
    wArm = 1'b1;
    step();
    wArm      = 1'b0;
    wStartHit = 1'b1;
    wStartBin = 8'd44;
    step();
    wStartHit = 1'b0;
    step();
    #2 wRstN = 1'b0;
    #1;
    chk_all_zero("rst_run");
    @(posedge wClk);
    #1 wRstN = 1'b1;
    step();
    chk("rst_run_idle", 32'(wBusy), 0);

    // Asynchronous reset mid-DONE
    run_meas(tbl[5], 1'b0);
    #2 wRstN = 1'b0;
    #1;
    chk_all_zero("rst_done");
    @(posedge wClk);
    #1 wRstN = 1'b1;
    step();
    chk("rst_done_idle_valid", 32'(res_if.wResultValid), 0);

    // Fresh measurement after reset
    run_meas(tbl[2], 1'b1);
    run_meas(tbl[0], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
